// File: rtl/tlut_gemm_engine.sv
// Temporal-LUT GEMM engine: inputs act as pulse lengths gating weights
// into per-output adder trees, with K accumulation and saturation.
module tlut_gemm_engine #(
  parameter int DIM_M        = 3,
  parameter int DIM_K        = 3,
  parameter int DIM_N        = 3,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int SIGNED_W     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_accumulate,
  input  logic [DIM_M*DIM_K-1:0][INPUT_WIDTH-1:0] input_bin,
  input  logic [DIM_K*DIM_N-1:0][WEIGHT_WIDTH-1:0] weight_bin,
  output logic out_valid,
  input  logic out_ready,
  output logic [DIM_M*DIM_N-1:0][ACC_WIDTH-1:0] accumulated_mult,
  output logic [DIM_M*DIM_N-1:0] overflow
);

  localparam int PS_W = WEIGHT_WIDTH + $clog2(DIM_K);
  localparam logic [PS_W-1:0] W_MASK =
    ~PS_W'({WEIGHT_WIDTH{1'b1}});
  localparam logic [ACC_WIDTH:0] P_MASK =
    ~(ACC_WIDTH+1)'({PS_W{1'b1}});
  localparam logic [ACC_WIDTH-1:0] S_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [DIM_M*DIM_K-1:0][INPUT_WIDTH-1:0]  a_q;
  logic [DIM_K*DIM_N-1:0][WEIGHT_WIDTH-1:0] w_q;
  logic [DIM_M*DIM_N-1:0][ACC_WIDTH-1:0]    acc_q, acc_nxt;
  logic [DIM_M*DIM_N-1:0] ovf_q, sat_nxt;
  logic [INPUT_WIDTH-1:0] cnt_q, max_q, max_in;

  logic [PS_W-1:0]      psum, wext;
  logic [ACC_WIDTH:0]   acc_x, ps_x, sum;
  logic [ACC_WIDTH-1:0] clamped;
  logic                 sat;

  always_comb begin
    max_in = '0;
    for (int e = 0; e < DIM_M*DIM_K; e++)
      if (input_bin[e] > max_in) max_in = input_bin[e];
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = (max_in != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_q == max_q - INPUT_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One pulse step: gate each weight by (cnt < a), tree-sum, saturate.
  always_comb begin
    acc_nxt = acc_q;
    sat_nxt = '0;
    psum    = '0;
    wext    = '0;
    acc_x   = '0;
    ps_x    = '0;
    sum     = '0;
    clamped = '0;
    sat     = 1'b0;
    for (int i = 0; i < DIM_M; i++) begin
      for (int j = 0; j < DIM_N; j++) begin
        psum = '0;
        for (int k = 0; k < DIM_K; k++) begin
          wext = PS_W'(w_q[k*DIM_N+j]);
          if ((SIGNED_W != 0) && w_q[k*DIM_N+j][WEIGHT_WIDTH-1])
            wext = wext | W_MASK;
          if (cnt_q < a_q[i*DIM_K+k]) psum = psum + wext;
        end
        acc_x = {(SIGNED_W != 0) && acc_q[i*DIM_N+j][ACC_WIDTH-1],
                 acc_q[i*DIM_N+j]};
        ps_x  = (ACC_WIDTH+1)'(psum);
        if ((SIGNED_W != 0) && psum[PS_W-1]) ps_x = ps_x | P_MASK;
        sum     = acc_x + ps_x;
        clamped = sum[ACC_WIDTH-1:0];
        sat     = 1'b0;
        if (SIGNED_W != 0) begin
          if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            sat     = 1'b1;
            clamped = sum[ACC_WIDTH] ? S_MIN : S_MAX;
          end
        end else if (sum[ACC_WIDTH]) begin
          sat     = 1'b1;
          clamped = '1;
        end
        acc_nxt[i*DIM_N+j] = clamped;
        sat_nxt[i*DIM_N+j] = sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      a_q   <= input_bin;
      w_q   <= weight_bin;
      max_q <= max_in;
      cnt_q <= '0;
      if (!in_accumulate) begin
        acc_q <= '0;
        ovf_q <= '0;
      end
    end else if (state_q == RUN) begin
      acc_q <= acc_nxt;
      ovf_q <= ovf_q | sat_nxt;
      cnt_q <= cnt_q + INPUT_WIDTH'(1);
    end
  end

  assign accumulated_mult = acc_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_tlut_gemm_engine.sv
// Bench for tlut_gemm_engine: an unsigned 8-bit-acc instance and a
// signed 16-bit-acc instance, checked against a pulse-level model.
module tb_tlut_gemm_engine;

  typedef int vec_t [9];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic valid_u, valid_s, accum, out_ready;
  logic [8:0][3:0] a_bus, w_bus;
  logic ready_u, ready_s, ov_u, ov_s;
  logic [8:0][7:0]  acc_u;
  logic [8:0][15:0] acc_s;
  logic [8:0] ovf_u, ovf_s;

  int n_assert = 0;
  int n_fail = 0;
  int m_acc [2][9];
  bit m_ovf [2][9];

  tlut_gemm_engine #(.ACC_WIDTH(8), .SIGNED_W(0)) u_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(valid_u), .in_ready(ready_u),
    .in_accumulate(accum),
    .input_bin(a_bus), .weight_bin(w_bus),
    .out_valid(ov_u), .out_ready(out_ready),
    .accumulated_mult(acc_u), .overflow(ovf_u)
  );

  tlut_gemm_engine #(.ACC_WIDTH(16), .SIGNED_W(1)) u_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(valid_s), .in_ready(ready_s),
    .in_accumulate(accum),
    .input_bin(a_bus), .weight_bin(w_bus),
    .out_valid(ov_s), .out_ready(out_ready),
    .accumulated_mult(acc_s), .overflow(ovf_s)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int maxv(input vec_t a);
    int m = 0;
    for (int e = 0; e < 9; e++) if (a[e] > m) m = a[e];
    return m;
  endfunction

  // C += A x B as max(A) pulse steps, clamping after every step.
  function automatic void model(input int d, input vec_t a,
                                input vec_t w, input bit acc_en);
    int hi, lo, s, t, wv;
    hi = d ? 32767 : 255;
    lo = d ? -32768 : 0;
    if (!acc_en)
      for (int e = 0; e < 9; e++) begin
        m_acc[d][e] = 0;
        m_ovf[d][e] = 1'b0;
      end
    for (int c = 0; c < maxv(a); c++)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          s = 0;
          for (int k = 0; k < 3; k++)
            if (a[i*3+k] > c) begin
              wv = w[k*3+j];
              if (d != 0 && wv > 7) wv = wv - 16;
              s += wv;
            end
          t = m_acc[d][i*3+j] + s;
          if (t > hi) begin t = hi; m_ovf[d][i*3+j] = 1'b1; end
          if (t < lo) begin t = lo; m_ovf[d][i*3+j] = 1'b1; end
          m_acc[d][i*3+j] = t;
        end
  endfunction

  task automatic start_tile(input int d, input vec_t a,
                            input vec_t w, input bit acc_en);
    @(negedge clk);
    check("in_ready_before", {31'd0, d ? ready_s : ready_u}, 32'd1);
    for (int e = 0; e < 9; e++) begin
      a_bus[e] = 4'(a[e]);
      w_bus[e] = 4'(w[e]);
    end
    accum = acc_en;
    if (d != 0) valid_s = 1'b1;
    else valid_u = 1'b1;
    @(posedge clk);
    #1;
    valid_u = 1'b0;
    valid_s = 1'b0;
    model(d, a, w, acc_en);
  endtask

  task automatic wait_done(input int d, input int lat);
    int n = 0;
    while (!(d ? ov_s : ov_u) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, lat);
  endtask

  task automatic check_out(input int d);
    logic [31:0] got, exp;
    logic [8:0] ev;
    for (int e = 0; e < 9; e++) begin
      got = d ? 32'(acc_s[e]) : 32'(acc_u[e]);
      exp = 32'(m_acc[d][e]) & (d ? 32'hFFFF : 32'hFF);
      check($sformatf("acc%0d[%0d]", d, e), got, exp);
      ev[e] = m_ovf[d][e];
    end
    check($sformatf("ovf%0d", d), 32'(d ? ovf_s : ovf_u), 32'(ev));
  endtask

  task automatic finish_tile(input int d);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_ready", {31'd0, d ? ready_s : ready_u}, 32'd1);
    check("valid_low", {31'd0, d ? ov_s : ov_u}, 32'd0);
  endtask

  task automatic run(input int d, input vec_t a,
                     input vec_t w, input bit acc_en);
    start_tile(d, a, w, acc_en);
    wait_done(d, maxv(a));
    check_out(d);
    finish_tile(d);
  endtask

  vec_t idx, zero, ta, tw, all15;
  int s1 [9] = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
  int s3 [9] = '{45, 54, 63, 126, 162, 198, 207, 255, 255};

  initial begin
    valid_u = 1'b0;
    valid_s = 1'b0;
    accum = 1'b0;
    out_ready = 1'b0;
    a_bus = '0;
    w_bus = '0;
    for (int e = 0; e < 9; e++) begin
      idx[e] = e;
      zero[e] = 0;
      all15[e] = 15;
    end

    #12;
    check("rst_ready", {31'd0, ready_u}, 32'd1);
    check("rst_valid", {31'd0, ov_u}, 32'd0);
    check("rst_acc", 32'(acc_u[8]) | 32'(acc_u[0]), 32'd0);
    check("rst_ovf", 32'(ovf_u), 32'd0);
    check("rst_acc_s", 32'(acc_s[4]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, idx, idx, 1'b0);
    for (int e = 0; e < 9; e++)
      check($sformatf("s1[%0d]", e), 32'(acc_u[e]), 32'(s1[e]));
    run(0, idx, idx, 1'b1);
    check("s2[8]", 32'(acc_u[8]), 32'd222);
    run(0, idx, idx, 1'b1);
    for (int e = 0; e < 9; e++)
      check($sformatf("s3[%0d]", e), 32'(acc_u[e]), 32'(s3[e]));
    check("s3_ovf", 32'(ovf_u), 32'h180);

    run(0, zero, idx, 1'b0);
    for (int e = 0; e < 9; e++) begin
      ta[e] = $urandom_range(0, 6);
      tw[e] = $urandom_range(0, 15);
    end
    run(0, ta, tw, 1'b0);
    run(0, zero, idx, 1'b1);

    start_tile(0, idx, idx, 1'b0);
    wait_done(0, 8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_u = ~valid_u;
      accum = 1'b0;
      for (int e = 0; e < 9; e++) a_bus[e] = 4'($urandom_range(1, 15));
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, ov_u}, 32'd1);
      check("bp_ready", {31'd0, ready_u}, 32'd0);
      check_out(0);
    end
    valid_u = 1'b0;
    finish_tile(0);

    start_tile(0, idx, idx, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, ov_u}, 32'd0);
    check("abort_acc", 32'(acc_u[8]) | 32'(acc_u[5]), 32'd0);
    check("abort_ovf", 32'(ovf_u), 32'd0);
    for (int d = 0; d < 2; d++)
      for (int e = 0; e < 9; e++) begin
        m_acc[d][e] = 0;
        m_ovf[d][e] = 1'b0;
      end
    @(negedge clk);
    rst_n = 1'b1;
    run(0, idx, idx, 1'b0);
    for (int e = 0; e < 9; e++)
      check($sformatf("post_rst[%0d]", e), 32'(acc_u[e]), 32'(s1[e]));

    run(1, all15, all15, 1'b0);
    for (int e = 0; e < 9; e++)
      check($sformatf("neg45[%0d]", e), 32'(acc_s[e]), 32'hFFD3);

    for (int t = 0; t < 16; t++) begin
      for (int e = 0; e < 9; e++) begin
        ta[e] = $urandom_range(0, (t % 3 == 0) ? 3 : 15);
        tw[e] = $urandom_range(0, 15);
      end
      run(t % 2, ta, tw, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
